booth_pp_switch: RTL

- Upstream stage of the 32x32 multiplier. Radix-4 Booth-encodes the multiplier operand and selects 16 partial products (PPs) from the multiplicand.
- Transposes the PPs into 64 per-column 16-bit vectors and registers them for the downstream Wallace column array.
- Single pipeline stage with a valid/ready handshake. Also carries the op tag and the correction fields needed by the final adder.

---
 rtl/mul_pkg.sv | 39 +++
 rtl/booth_sel.sv | 53 +++++
 rtl/booth_pp_switch.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/mul_pkg.sv
// -----------------------------------------------------------------------------
// mul_pkg
// Shared definitions for the 32x32 multiplier front end:
//   - radix-4 Booth digit encoding (booth_digit_e) and a decode helper
//   - partial-product geometry: row count, column count, column-vector width
//   - col_bus_t: the flattened bus of 64 per-column 16-bit vectors
// No ports (package).
// -----------------------------------------------------------------------------
package mul_pkg;

  localparam int ROWS  = 16;            // one row per radix-4 digit of a 32-bit y
  localparam int COLS  = 64;            // full double-width product
  localparam int COL_W = ROWS;          // one bit per row in each column vector
  localparam int BUS_W = COLS * COL_W;  // 1024

  typedef logic [BUS_W-1:0] col_bus_t;

  typedef enum logic [2:0] {
    ZERO = 3'd0,
    POS1 = 3'd1,
    POS2 = 3'd2,
    NEG1 = 3'd3,
    NEG2 = 3'd4
  } booth_digit_e;

  // grp = {y[2i+1], y[2i], y[2i-1]}
  function automatic booth_digit_e booth_decode(input logic [2:0] grp);
    booth_digit_e d;
    case (grp)
      3'b001, 3'b010: d = POS1;
      3'b011:         d = POS2;
      3'b100:         d = NEG2;
      3'b101, 3'b110: d = NEG1;
      default:        d = ZERO;  // 000 and 111
    endcase
    return d;
  endfunction

endpackage

// File: rtl/booth_sel.sv
// -----------------------------------------------------------------------------
// booth_sel
// Selects one Booth partial-product row before its 2i left shift.
// Ports:
//   grp  in  3   digit group {y[2i+1], y[2i], y[2i-1]}
//   x    in  32  multiplicand, two's complement
//   row  out 64  0, x or 2x sign-extended to 64 bits; bitwise inverted when
//                the digit is negative
//   neg  out 1   +1 correction that completes the two's-complement negation
// -----------------------------------------------------------------------------
module booth_sel
  import mul_pkg::*;
(
  input  logic [2:0]  grp,
  input  logic [31:0] x,
  output logic [63:0] row,
  output logic        neg
);

  booth_digit_e digit;
  logic [63:0]  x_ext;
  logic         x_zero;

  assign digit  = booth_decode(grp);
  assign x_ext  = {{32{x[31]}}, x};
  assign x_zero = (x == 32'd0);

  always_comb begin
    row = '0;
    neg = 1'b0;
    // A zero magnitude never yields an inverted row, so -0 stays all-zero
    // with no correction bit.
    if (!x_zero) begin
      case (digit)
        POS1: row = x_ext;
        POS2: row = x_ext << 1;          // 2x is exact in 64 bits, no overflow
        NEG1: begin
          row = ~x_ext;
          neg = 1'b1;
        end
        NEG2: begin
          row = ~(x_ext << 1);
          neg = 1'b1;
        end
        default: begin
          row = '0;
          neg = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/booth_pp_switch.sv
// -----------------------------------------------------------------------------
// booth_pp_switch
// Radix-4 Booth encodes in_y, builds 16 partial-product rows from in_x,
// transposes them into 64 column vectors and registers the result for the
// Wallace column array. One pipeline stage with valid/ready handshake.
//
// Ports:
//   clk, resetn               clock; asynchronous active-low reset
//   in_valid / in_ready       upstream handshake
//   in_x, in_y                multiplicand / multiplier (two's complement)
//   in_unsigned, in_tag       passed through with the op
//   out_valid / out_ready     downstream handshake
//   out_col                   column c at [16c+15:16c], bit r = row r
//   out_neg15                 +1 for row 15, carry-in at column 30
//   out_x, out_y, out_unsigned, out_tag   registered pass-through fields
//
// Build option: define MUL_PP_SKID_EN to add a skid register behind the
// output register (2 entries total) so that in_ready comes straight from a
// flop instead of being combinational with out_ready.
// -----------------------------------------------------------------------------
module booth_pp_switch
  import mul_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_x,
  input  logic [31:0]      in_y,
  input  logic             in_unsigned,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output col_bus_t         out_col,
  output logic             out_neg15,
  output logic [31:0]      out_x,
  output logic [31:0]      out_y,
  output logic             out_unsigned,
  output logic [TAG_W-1:0] out_tag
);

  // ---------------------------------------------------------------------------
  // Row generation
  // ---------------------------------------------------------------------------
  logic [32:0]   y_pad;                 // y with the implicit y[-1]=0 appended
  logic [63:0]   sel_row [ROWS];
  logic [ROWS-1:0] sel_neg;
  logic [63:0]   pp_row  [ROWS];
  col_bus_t      col_in;
  logic          accept;

  assign y_pad = {in_y, 1'b0};

  genvar gi, gj;
  generate
    for (gi = 0; gi < ROWS; gi++) begin : g_row
      booth_sel u_sel (
        .grp (y_pad[2*gi+2 : 2*gi]),
        .x   (in_x),
        .row (sel_row[gi]),
        .neg (sel_neg[gi])
      );
      if (gi == 0) begin : g_first
        assign pp_row[gi] = sel_row[gi];
      end else begin : g_rest
        // The previous row's +1 lands at bit 2(i-1); that position is always
        // zero here because this row is shifted by 2i.
        assign pp_row[gi] = (sel_row[gi] << (2*gi))
                          | (64'(sel_neg[gi-1]) << (2*gi-2));
      end
    end

    // Transpose: column c, row r
    for (gi = 0; gi < COLS; gi++) begin : g_col
      for (gj = 0; gj < ROWS; gj++) begin : g_bit
        assign col_in[gi*COL_W + gj] = pp_row[gj][gi];
      end
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Output register
  // ---------------------------------------------------------------------------
  logic             valid_q, valid_d;
  col_bus_t         col_q, col_d;
  logic             neg15_q, neg15_d;
  logic [31:0]      x_q, x_d, y_q, y_d;
  logic             uns_q, uns_d;
  logic [TAG_W-1:0] tag_q, tag_d;

  assign accept = in_valid && in_ready;

`ifdef MUL_PP_SKID_EN
  // Skid entry catches an op accepted while the output register is stalled.
  // in_ready is the registered "skid empty" flag.
  logic             sk_valid_q, sk_valid_d;
  col_bus_t         sk_col_q, sk_col_d;
  logic             sk_neg15_q, sk_neg15_d;
  logic [31:0]      sk_x_q, sk_x_d, sk_y_q, sk_y_d;
  logic             sk_uns_q, sk_uns_d;
  logic [TAG_W-1:0] sk_tag_q, sk_tag_d;
  logic             in_ready_q;

  assign in_ready = in_ready_q;

  always_comb begin
    valid_d    = valid_q;
    col_d      = col_q;
    neg15_d    = neg15_q;
    x_d        = x_q;
    y_d        = y_q;
    uns_d      = uns_q;
    tag_d      = tag_q;
    sk_valid_d = sk_valid_q;
    sk_col_d   = sk_col_q;
    sk_neg15_d = sk_neg15_q;
    sk_x_d     = sk_x_q;
    sk_y_d     = sk_y_q;
    sk_uns_d   = sk_uns_q;
    sk_tag_d   = sk_tag_q;
    if (!valid_q || out_ready) begin
      // Output register free this cycle: oldest op (skid) goes first.
      if (sk_valid_q) begin
        valid_d    = 1'b1;
        col_d      = sk_col_q;
        neg15_d    = sk_neg15_q;
        x_d        = sk_x_q;
        y_d        = sk_y_q;
        uns_d      = sk_uns_q;
        tag_d      = sk_tag_q;
        sk_valid_d = 1'b0;
      end else if (accept) begin
        valid_d = 1'b1;
        col_d   = col_in;
        neg15_d = sel_neg[ROWS-1];
        x_d     = in_x;
        y_d     = in_y;
        uns_d   = in_unsigned;
        tag_d   = in_tag;
      end else begin
        valid_d = 1'b0;
      end
    end else if (accept) begin
      sk_valid_d = 1'b1;
      sk_col_d   = col_in;
      sk_neg15_d = sel_neg[ROWS-1];
      sk_x_d     = in_x;
      sk_y_d     = in_y;
      sk_uns_d   = in_unsigned;
      sk_tag_d   = in_tag;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sk_valid_q <= 1'b0;
      sk_col_q   <= '0;
      sk_neg15_q <= 1'b0;
      sk_x_q     <= '0;
      sk_y_q     <= '0;
      sk_uns_q   <= 1'b0;
      sk_tag_q   <= '0;
      in_ready_q <= 1'b1;
    end else begin
      sk_valid_q <= sk_valid_d;
      sk_col_q   <= sk_col_d;
      sk_neg15_q <= sk_neg15_d;
      sk_x_q     <= sk_x_d;
      sk_y_q     <= sk_y_d;
      sk_uns_q   <= sk_uns_d;
      sk_tag_q   <= sk_tag_d;
      in_ready_q <= !sk_valid_d;
    end
  end
`else
  assign in_ready = !valid_q || out_ready;

  always_comb begin
    valid_d = valid_q;
    col_d   = col_q;
    neg15_d = neg15_q;
    x_d     = x_q;
    y_d     = y_q;
    uns_d   = uns_q;
    tag_d   = tag_q;
    if (accept) begin
      valid_d = 1'b1;
      col_d   = col_in;
      neg15_d = sel_neg[ROWS-1];
      x_d     = in_x;
      y_d     = in_y;
      uns_d   = in_unsigned;
      tag_d   = in_tag;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q <= 1'b0;
      col_q   <= '0;
      neg15_q <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      uns_q   <= 1'b0;
      tag_q   <= '0;
    end else begin
      valid_q <= valid_d;
      col_q   <= col_d;
      neg15_q <= neg15_d;
      x_q     <= x_d;
      y_q     <= y_d;
      uns_q   <= uns_d;
      tag_q   <= tag_d;
    end
  end

  assign out_valid    = valid_q;
  assign out_col      = col_q;
  assign out_neg15    = neg15_q;
  assign out_x        = x_q;
  assign out_y        = y_q;
  assign out_unsigned = uns_q;
  assign out_tag      = tag_q;

endmodule
